// File: rtl/picomips_pkg.sv
// picomips_pkg
//   Shared definitions for the picoMIPS sequencer: the control state
//   enumeration and the opcode values of the top six instruction bits.
//   This package is the single source of truth for opcode encodings.
package picomips_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MULW   = 3'd3,
      ST_WAITIN = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_NOP    = 6'h00;
   localparam logic [5:0] OP_ADD    = 6'h01;
   localparam logic [5:0] OP_ADDI   = 6'h02;
   localparam logic [5:0] OP_MUL    = 6'h03;
   localparam logic [5:0] OP_WAITIN = 6'h04;
   localparam logic [5:0] OP_HALT   = 6'h3F;

   // True for every opcode the sequencer understands.
   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_NOP) || (op == OP_ADD) || (op == OP_ADDI) ||
             (op == OP_MUL) || (op == OP_WAITIN) || (op == OP_HALT);
   endfunction

endpackage

// File: rtl/picomips_sequencer_if.sv
// picomips_sequencer_if
//   Bundle of all sequencer control signals except clock and reset.
//   Ports (from the sequencer's point of view):
//     run, opcode, mult_done, in_valid       : inputs from the core
//     ir_load, PCincr, w1, imm, mult_start,
//     in_ack, halted                         : combinational strobes
//     err, illegal                           : sticky status flags
//     retired[RET_W-1:0]                     : retired-instruction count
//   Modports: master = sequencer side, slave = core / environment side.
interface picomips_sequencer_if #(
   parameter int RET_W = 16
);
   logic             run;
   logic [5:0]       opcode;
   logic             mult_done;
   logic             in_valid;
   logic             ir_load;
   logic             PCincr;
   logic             w1;
   logic             imm;
   logic             mult_start;
   logic             in_ack;
   logic             halted;
   logic             err;
   logic             illegal;
   logic [RET_W-1:0] retired;

   modport master (
      input  run, opcode, mult_done, in_valid,
      output ir_load, PCincr, w1, imm, mult_start, in_ack, halted,
             err, illegal, retired
   );

   modport slave (
      output run, opcode, mult_done, in_valid,
      input  ir_load, PCincr, w1, imm, mult_start, in_ack, halted,
             err, illegal, retired
   );
endinterface

// File: rtl/opcodes.sv
// opcodes.sv
//   Legacy macro names for the picoMIPS opcodes. Each macro simply aliases
//   the matching localparam in picomips_pkg so that encodings live in one
//   place only.
`ifndef PICOMIPS_OPCODES_SV
`define PICOMIPS_OPCODES_SV
`define PICO_NOP    picomips_pkg::OP_NOP
`define PICO_ADD    picomips_pkg::OP_ADD
`define PICO_ADDI   picomips_pkg::OP_ADDI
`define PICO_MUL    picomips_pkg::OP_MUL
`define PICO_WAITIN picomips_pkg::OP_WAITIN
`define PICO_HALT   picomips_pkg::OP_HALT
`endif

// File: rtl/picomips_timeout_cnt.sv
// picomips_timeout_cnt
//   Loadable down-counter with a terminal-count flag.
//   Ports:
//     clk, nReset   : clock, asynchronous active-low reset (count -> 0)
//     load_i        : load load_val_i (has priority over dec_i)
//     load_val_i    : value loaded on load_i
//     dec_i         : decrement by one; holds at zero
//     tc_o          : count is zero
module picomips_timeout_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/picomips_sequencer.sv
// picomips_sequencer
//   Multi-cycle control FSM for the picoMIPS core: fetch, decode, execute,
//   plus a multiplier handshake with timeout and a blocking switch input.
//   Ports:
//     clk    : system clock, rising edge
//     nReset : asynchronous active-low reset
//     bus    : picomips_sequencer_if.master (all control/status signals)
//   Strobes and halted are combinational from state and inputs and are
//   held low while nReset is low.
module picomips_sequencer
   import picomips_pkg::*;
#(
   parameter int MUL_MAX_CYCLES = 16,
   parameter int RET_W          = 16
) (
   input  logic clk,
   input  logic nReset,
   picomips_sequencer_if.master bus
);
   // The down-counter is loaded with MAX-1 on the start cycle; reaching zero
   // in MULW corresponds to an up-count of MAX-1, i.e. the last allowed cycle.
   localparam logic [7:0] MUL_LOAD = 8'(MUL_MAX_CYCLES - 1);

   state_t           state_q, state_d;
   logic [RET_W-1:0] retired_q, retired_d;
   logic             err_q, err_d;
   logic             illegal_q, illegal_d;

   logic ir_load_c, pcincr_c, w1_c, imm_c, mstart_c, in_ack_c, halted_c;
   logic cnt_load, cnt_dec, cnt_tc;

   picomips_timeout_cnt #(.W(8)) u_mul_timeout (
      .clk        (clk),
      .nReset     (nReset),
      .load_i     (cnt_load),
      .load_val_i (MUL_LOAD),
      .dec_i      (cnt_dec),
      .tc_o       (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      ir_load_c = 1'b0;
      pcincr_c  = 1'b0;
      w1_c      = 1'b0;
      imm_c     = 1'b0;
      mstart_c  = 1'b0;
      in_ack_c  = 1'b0;
      halted_c  = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      err_d     = err_q;
      illegal_d = illegal_q;

      case (state_q)
         ST_FETCH: begin
            ir_load_c = bus.run;
            if (bus.run)
               state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (bus.opcode)
               OP_NOP: begin
                  pcincr_c = 1'b1;
                  state_d  = ST_FETCH;
               end
               OP_ADD, OP_ADDI: state_d = ST_EXEC;
               OP_MUL: begin
                  // mult_done is not looked at here, so a stale done is ignored.
                  mstart_c = 1'b1;
                  cnt_load = 1'b1;
                  state_d  = ST_MULW;
               end
               OP_WAITIN: state_d = ST_WAITIN;
               OP_HALT:   state_d = ST_HALT;
               default: begin
                  pcincr_c  = 1'b1;
                  illegal_d = 1'b1;
                  state_d   = ST_FETCH;
               end
            endcase
         end
         ST_EXEC: begin
            // Opcode is still held by the instruction register here.
            w1_c     = 1'b1;
            pcincr_c = 1'b1;
            imm_c    = (bus.opcode == OP_ADDI);
            state_d  = ST_FETCH;
         end
         ST_MULW: begin
            if (bus.mult_done) begin
               // A result arriving on the last allowed cycle still wins.
               w1_c     = 1'b1;
               pcincr_c = 1'b1;
               state_d  = ST_FETCH;
            end else if (cnt_tc) begin
               err_d    = 1'b1;
               pcincr_c = 1'b1;
               state_d  = ST_FETCH;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_WAITIN: begin
            if (bus.in_valid) begin
               in_ack_c = 1'b1;
               w1_c     = 1'b1;
               pcincr_c = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         ST_HALT: halted_c = 1'b1;
         default: state_d = ST_FETCH;
      endcase

      retired_d = retired_q + RET_W'(pcincr_c);
   end

   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q   <= ST_FETCH;
         retired_q <= '0;
         err_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         err_q     <= err_d;
         illegal_q <= illegal_d;
      end
   end

   // Gate strobes with nReset so they drop the instant reset is asserted.
   assign bus.ir_load    = nReset & ir_load_c;
   assign bus.PCincr     = nReset & pcincr_c;
   assign bus.w1         = nReset & w1_c;
   assign bus.imm        = nReset & imm_c;
   assign bus.mult_start = nReset & mstart_c;
   assign bus.in_ack     = nReset & in_ack_c;
   assign bus.halted     = nReset & halted_c;
   assign bus.err        = err_q;
   assign bus.illegal    = illegal_q;
   assign bus.retired    = retired_q;
endmodule

// File: doc/picomips_sequencer.md
Name: picomips_sequencer

Overview:
- Multi-cycle control FSM for the picoMIPS core.
- Sits between the instruction register/decoder and the PC, register file and ALU.
- Sequences fetch, decode and execute, and handles two handshakes: a multi-cycle multiplier and a blocking switch-input instruction.
- Gates the PC-increment and register-write strobes so each instruction retires exactly once.

Parameters:
MUL_MAX_CYCLES, 16, cycles allowed in MULW before the timeout abort (range 1..255).
RET_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
nReset  input  1  asynchronous active-low reset.
run  input  1  permits a new fetch; sampled only in FETCH.
opcode  input  6  top 6 bits of the instruction register, valid from the cycle after ir_load.
mult_done  input  1  multiplier result valid.
in_valid  input  1  switch input value valid.
ir_load  output  1  load the instruction register.
PCincr  output  1  PC increments this cycle.
w1  output  1  register-file write enable for the destination register.
imm  output  1  steer immediate data to ALU operand a.
mult_start  output  1  single-cycle multiplier start pulse.
in_ack  output  1  consumes the switch input.
halted  output  1  core is stopped.
err  output  1  sticky flag: multiplier timeout.
illegal  output  1  sticky flag: unknown opcode decoded.
retired  output  RET_W  count of retired instructions.

Behaviour:
- State register: FETCH, DECODE, EXEC, MULW, WAITIN, HALT.
  - Updates on clk rising edge.
  - nReset low forces, immediately and asynchronously: state=FETCH, mul_cnt=0, retired=0, err=0, illegal=0.
- Output gating: all strobe outputs and halted are combinational from state and inputs, and are forced to 0 while nReset is low.
- FETCH:
  - ir_load=run.
  - run=1 goes to DECODE; run=0 stays in FETCH with no strobes.
- DECODE:
  - NOP: PCincr=1, go to FETCH (2 cycles total).
  - ADD, ADDI: go to EXEC.
  - MUL: mult_start=1, mul_cnt cleared, go to MULW.
  - WAITIN: go to WAITIN.
  - HALT: go to HALT.
  - Any other opcode: treated as NOP and illegal is set (sticky).
- EXEC:
  - w1=1, PCincr=1, imm=1 only for ADDI.
  - Go to FETCH (ADD/ADDI take 3 cycles).
- MULW:
  - Each cycle with mult_done=0, mul_cnt increments.
  - mult_done=1: w1=1, PCincr=1, go to FETCH.
  - Timeout: mul_cnt==MUL_MAX_CYCLES-1 with mult_done=0 sets err, PCincr=1, w1=0, go to FETCH.
  - A mult_done asserted during the DECODE start cycle is ignored.
  - mult_done has priority over the timeout in the same cycle.
- WAITIN:
  - in_valid=1: in_ack=1, w1=1, PCincr=1, go to FETCH.
  - Otherwise hold with all strobes 0. No timeout.
- HALT: halted=1. Absorbing; run is ignored and only nReset exits.
- run only gates FETCH; deasserting it mid-instruction does not abort the instruction.
- retired increments by 1 on every cycle with PCincr=1 and wraps from 2^RET_W-1 to 0.
- Per instruction, exactly one PCincr pulse and at most one w1 pulse; mult_start and in_ack are never high in the same cycle.

Decomposition:
- picomips_pkg holds the state enum state_t and the opcode localparams: NOP=6'h00, ADD=6'h01, ADDI=6'h02, MUL=6'h03, WAITIN=6'h04, HALT=6'h3F.
- opcodes.sv macros alias these localparams, so the package is the single source of truth.
- One sub-module: picomips_timeout_cnt. It is a loadable down-counter with a terminal-count output, used for MULW and parameterised by width.

Test Plan:
1. Reset, run=1, opcode=ADDI. Required: ir_load in cycle 0; DECODE in cycle 1; cycle 2 has w1=imm=PCincr=1; retired=1; then ir_load again in cycle 3.
2. opcode=MUL with mult_done raised 3 cycles after mult_start. Required: mult_start high exactly 1 cycle; w1=PCincr=1 in the mult_done cycle; instruction takes 5 cycles; err=0.
3. opcode=MUL, mult_done held 0, MUL_MAX_CYCLES=16. Required: after 16 MULW cycles err=1, PCincr=1, w1=0, return to FETCH; a following NOP retires normally with err still 1.
4. opcode=WAITIN, in_valid=0 for 10 cycles then 1. Required: no strobes during the wait; in_ack=w1=PCincr=1 in a single cycle; in_valid held high afterwards causes no second in_ack.
5. opcode=6'h2A. Required: illegal=1, PCincr=1 in DECODE, retired increments. Then opcode=HALT: halted=1 and stays 1 across 20 cycles with run toggling.
6. nReset pulsed low mid-MULW. Required: outputs 0 and state FETCH within the same cycle (no clock needed); retired=0, err=0. Separately, run 2^RET_W NOPs and check that retired wraps to 0.
